// File: rtl/cacheline_arbiter_if.sv
// cacheline_arbiter_if: icache, dcache and memory line-port signals of the cacheline arbiter.
interface cacheline_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin sharing of one line memory port between icache and dcache.
module cacheline_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic clk,
  input logic rst,
  cacheline_arbiter_if.slave bus
);
  localparam int OFF = $clog2(LINE_WIDTH / 8);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  state_t state, state_n;
  logic last_d, cmd_op, grant_i, grant_d, want_i, want_d, serve;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LINE_WIDTH-1:0] cmd_wdata;
  assign want_i = bus.i_read;
  assign want_d = bus.d_read | bus.d_write;
  // On contention the cache that was not granted last wins.
  always_comb begin
    grant_d = state == IDLE && want_d && (!want_i || !last_d);
    grant_i = state == IDLE && want_i && !grant_d;
    serve   = state == SERVE_I || state == SERVE_D;
    state_n = state == IDLE ? (grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE) :
              state == DONE ? IDLE : bus.mem_resp ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d    <= 1'b0;
      cmd_op    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (grant_d) begin
      last_d    <= 1'b1;
      cmd_op    <= bus.d_write;
      cmd_addr  <= {bus.d_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
      cmd_wdata <= bus.d_wdata;
    end else if (grant_i) begin
      last_d    <= 1'b0;
      cmd_op    <= 1'b0;
      cmd_addr  <= {bus.i_address[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    end
  end
  assign bus.mem_read    = serve && !cmd_op;
  assign bus.mem_write   = serve && cmd_op;
  assign bus.mem_address = serve ? cmd_addr : '0;
  assign bus.mem_wdata   = serve ? cmd_wdata : '0;
  assign bus.i_resp      = state == SERVE_I && bus.mem_resp;
  assign bus.d_resp      = state == SERVE_D && bus.mem_resp;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: randomized transaction-level check of the cacheline arbiter.
module tb_cacheline_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cacheline_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
  cacheline_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [LW-1:0] env_mem [logic [AW-1:0]];
  logic [LW-1:0] ref_mem [logic [AW-1:0]];
  bit mi_pend, md_pend, md_wr, md_illegal, last_d;
  logic [AW-1:0] mi_addr, md_addr;
  logic [LW-1:0] md_wdata;
  task automatic check(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction
  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31);
  endfunction
  function automatic logic [AW-1:0] aligned(logic [AW-1:0] a);
    return a - (a % (LW / 8));
  endfunction
  function automatic logic [LW-1:0] env_rd(logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : '0;
  endfunction
  function automatic logic [LW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction
  task automatic apply();
    bus.i_read    = mi_pend;
    bus.i_address = mi_addr;
    bus.d_read    = md_pend && (!md_wr || md_illegal);
    bus.d_write   = md_pend && md_wr;
    bus.d_address = md_addr;
    bus.d_wdata   = md_wdata;
  endtask
  task automatic new_i();
    mi_pend = 1;
    mi_addr = rand_addr();
  endtask
  task automatic new_d();
    md_pend    = 1;
    md_wr      = $urandom_range(0, 1) == 1;
    md_illegal = md_wr && $urandom_range(0, 3) == 0;
    md_addr    = rand_addr();
    md_wdata   = rand_line();
  endtask
  // One granted transaction, from the IDLE sampling edge through DONE back to IDLE.
  task automatic serve_one(int lat, bit again);
    bit exp_d, exp_wr;
    logic [AW-1:0] ea;
    logic [LW-1:0] ew;
    int k;
    exp_d  = md_pend && (!mi_pend || !last_d);
    last_d = exp_d;
    ea     = aligned(exp_d ? md_addr : mi_addr);
    exp_wr = exp_d && md_wr;
    ew     = md_wdata;
    k = 0;
    do begin
      @(posedge clk); #1;
      @(negedge clk);
      k++;
    end while (!(bus.mem_read || bus.mem_write) && k < 6);
    check("grant_latency", k, 1);
    if (!(bus.mem_read || bus.mem_write)) return;
    check("cmd_op", {bus.mem_read, bus.mem_write}, exp_wr ? 2'b01 : 2'b10);
    if (exp_wr) check("cmd_wdata", bus.mem_wdata, ew);
    if (lat == 0) lat = $urandom_range(1, 4);
    for (int j = 1; j <= lat; j++) begin
      bus.mem_resp  = j == lat;
      bus.mem_rdata = exp_wr ? rand_line() : env_rd(bus.mem_address);
      #1;
      check("hold_addr", bus.mem_address, ea);
      if (j < lat) begin
        check("early_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        @(posedge clk); #1;
        if (j == 1 && exp_d) begin
          bus.d_address = ~md_addr;
          bus.d_wdata   = ~md_wdata;
          bus.d_write   = $urandom_range(0, 1) == 1;
          bus.d_read    = 1'b0;
        end else if (j == 1) begin
          bus.i_address = ~mi_addr;
          bus.i_read    = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
      end
    end
    check("resp_route", {bus.i_resp, bus.d_resp}, exp_d ? 2'b01 : 2'b10);
    if (exp_wr) begin
      env_mem[bus.mem_address] = bus.mem_wdata;
      ref_mem[ea] = ew;
    end else begin
      check("rdata", exp_d ? bus.d_rdata : bus.i_rdata, ref_rd(ea));
    end
    @(posedge clk); #1;
    bus.mem_resp = $urandom_range(0, 1) == 1;
    if (exp_d) begin
      if (again) new_d(); else md_pend = 0;
    end else begin
      if (again) new_i(); else mi_pend = 0;
    end
    apply();
    @(negedge clk);
    check("done_quiet", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 4'b0);
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
  endtask
  initial begin
    logic [LW-1:0] line;
    mi_pend = 0; md_pend = 0; md_wr = 0; md_illegal = 0; last_d = 0;
    mi_addr = '0; md_addr = '0; md_wdata = '0;
    apply();
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 4'b0);
    check("rst_addr", bus.mem_address, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    line = rand_line();
    env_mem[32'h60] = line;
    ref_mem[32'h60] = line;
    mi_pend = 1; mi_addr = 32'h0000_0064;
    apply();
    serve_one(3, 0);
    md_pend = 1; md_wr = 1; md_illegal = 0; md_addr = 32'h8000_01E0; md_wdata = {32{8'hA5}};
    apply();
    serve_one(2, 0);
    check("mem_holds", env_rd(32'h8000_01E0), {32{8'hA5}});
    md_pend = 1; md_wr = 0;
    apply();
    serve_one(0, 0);
    // Reset one cycle into a writeback abandons it; last_grant returns to I.
    md_pend = 1; md_wr = 1; md_illegal = 0; md_addr = rand_addr(); md_wdata = rand_line();
    apply();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre", bus.mem_write, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_same_cycle", bus.mem_write, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    md_pend = 0;
    last_d = 0;
    apply();
    bus.mem_resp = 1'b1;
    @(negedge clk);
    check("rst_abort", {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 4'b0);
    @(posedge clk); #1;
    bus.mem_resp = 1'b0;
    new_i(); new_d();
    apply();
    serve_one(0, 0);
    serve_one(0, 0);
    new_i(); new_d();
    apply();
    repeat (4) serve_one(0, 1);
    serve_one(0, 0);
    serve_one(0, 0);
    md_pend = 1; md_wr = 1; md_illegal = 1; md_addr = rand_addr(); md_wdata = rand_line();
    apply();
    serve_one(0, 0);
    repeat (40) begin
      if (!mi_pend && $urandom_range(0, 1) == 1) new_i();
      if (!md_pend && $urandom_range(0, 1) == 1) new_d();
      if (!mi_pend && !md_pend) new_d();
      apply();
      serve_one(0, $urandom_range(0, 1) == 1);
    end
    while (mi_pend || md_pend) serve_one(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares the single physical cacheline memory port between the instruction cache (read-only) and the data cache (read/write) of the pipelined core.
- Sits between the two L1 caches and the memory model or burst adapter.
- Grants one whole-line transaction at a time.
- Latches the granted command and routes the response back to its owner.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cacheline width in bits. Offset bits = log2(LINE_WIDTH/8).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_read  in  1  icache line-read request; level, held until i_resp.
- i_address  in  ADDR_WIDTH  icache request address.
- i_rdata  out  LINE_WIDTH  line returned to icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line-read request; level.
- d_write  in  1  dcache line-write request; level.
- d_address  in  ADDR_WIDTH  dcache request address.
- d_wdata  in  LINE_WIDTH  dcache writeback line.
- d_rdata  out  LINE_WIDTH  line returned to dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_address  out  ADDR_WIDTH  line-aligned memory address.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_rdata  in  LINE_WIDTH  memory read data; valid while mem_resp=1.
- mem_resp  in  1  memory completion, one or more cycles high.

Behaviour:
- States:
  - IDLE: no command.
  - SERVE_I: icache transaction outstanding.
  - SERVE_D: dcache transaction outstanding.
  - DONE: one bubble cycle so the owner can drop its request.
- Reset values:
  - state=IDLE, last_grant=I.
  - mem_read=mem_write=0, mem_address=0, mem_wdata=0.
  - i_resp=d_resp=0.
  - cmd_addr/cmd_wdata/cmd_op registers=0.
- IDLE transitions:
  - Only i_read: latch i_address with the offset bits cleared, op=READ, then go to SERVE_I.
  - Only d_read or d_write: latch d_address with the offset bits cleared, d_wdata, and op (WRITE if d_write, else READ), then go to SERVE_D.
  - d_read and d_write both high (illegal): WRITE is taken.
  - Both caches requesting: round-robin. Grant the cache that is not last_grant; update last_grant on every grant.
  - No request: stay in IDLE.
- Latency: a request sampled in IDLE at edge N drives mem_read or mem_write during cycle N+1 (the state is registered). Minimum request-to-resp is 2 cycles.
- SERVE_x: mem_read/mem_write = latched op; mem_address = cmd_addr; mem_wdata = cmd_wdata. All are driven purely from registers; requester inputs are ignored after the grant.
- On the first cycle of SERVE_x with mem_resp=1:
  - Assert the owner's resp for exactly that cycle (combinational from state & mem_resp).
  - For a read, x_rdata = mem_rdata in that same cycle.
  - Next state is DONE.
- DONE: no memory command and no resp, even if mem_resp is still high. Next state is IDLE, where requests are re-sampled.
- Back-to-back throughput: one line per (memory latency + 2) cycles.
- i_rdata/d_rdata outside their resp cycle: don't-care. The implementation drives mem_rdata through directly.
- A requester dropping its request mid-SERVE: the transaction still completes and resp still pulses.
- rst asserted in any state: IDLE on the next edge, and all commands drop that cycle. The outstanding memory transaction is abandoned; no resp is generated for it.
- mem_resp while in IDLE or DONE: ignored.

Test Plan:
- Single icache read: i_read=1, i_address=0x0000_0064, memory latency 3 → mem_read high with mem_address=0x0000_0060. i_resp pulses 1 cycle with i_rdata equal to the memory line. d_resp stays 0.
- Dcache writeback: d_write=1, d_address=0x8000_01E0, d_wdata=pattern A5.. → mem_write=1 with the same address and data. d_resp pulses once. Memory then holds the pattern at 0x8000_01E0.
- Simultaneous requests after reset (last_grant=I): i_read and d_read both held → the dcache is served first, then the icache. Exactly one resp each, in the order d then i, separated by the DONE/IDLE gap.
- Continuous contention, 4 transactions, both requesters re-asserting immediately → grants alternate D,I,D,I. mem_read/mem_write are never both high, and never high in DONE.
- Illegal d_read=d_write=1 → treated as a write. Separately, d_address changes mid-SERVE → mem_address stays at the latched value.
- rst pulsed during SERVE_D, 1 cycle after mem_write rises → mem_write=0 on the next cycle and state=IDLE. No d_resp; the next request is granted normally.
